// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state codes,
// the default pattern and a frame-length helper for benches.
package seq_pattern_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1101;

  // Busy cycles of a frame: every repetition plus the gaps between them.
  function automatic int frame_len(input int width, input int reps, input int gap);
    if (reps <= 0) begin
      return 0;
    end else begin
      return reps * width + (reps - 1) * gap;
    end
  endfunction

endpackage

// File: rtl/pattern_shifter.sv
// Loadable left-shift register holding the bits still to be sent.
// head is the bit to put on the line this edge: the incoming MSB on load,
// otherwise the MSB of the remaining bits. last means nothing remains.
module pattern_shifter
  import seq_pattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             head,
  output logic             last
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next contents: load drops the MSB (it goes out now), shift consumes one bit.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = {din[WIDTH-2:0], 1'b0};
      cnt_d  = CW'(WIDTH - 1);
    end else if (shift) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      cnt_d  = cnt_q - CW'(1'b1);
    end else begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = load ? din[WIDTH-1] : sreg_q[WIDTH-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern/repeat/gap request in IDLE and
// sends the pattern MSB-first, repeated reps times with gap idle cycles between.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               REPW        = 4,
  parameter int               GAPW        = 4,
  parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(SEQ_DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [REPW-1:0]  reps_in,
  input  logic [GAPW-1:0]  gap_in,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [REPW-1:0]  rep_q, rep_d;
  logic [GAPW-1:0]  gap_q, gap_d;
  logic [GAPW-1:0]  gcnt_q, gcnt_d;
  logic             o_q, o_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic             sh_load_s, sh_shift_s, sh_head_s, sh_last_s;
  logic [WIDTH-1:0] sh_din_s, new_pat_s;
  logic             last_rep_s, gap_end_s;

  assign new_pat_s  = use_def ? DEF_PATTERN : pattern_in;
  assign last_rep_s = (rep_q == REPW'(1'b1));
  assign gap_end_s  = (gcnt_q == GAPW'(1'b1));

  pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load_s),
    .shift (sh_shift_s),
    .din   (sh_din_s),
    .head  (sh_head_s),
    .last  (sh_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (reps_in != '0)) state_d = ST_SHIFT;
        else                          state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (!sh_last_s)           state_d = ST_SHIFT;
        else if (last_rep_s)      state_d = ST_IDLE;
        else if (gap_q != '0)     state_d = ST_GAP;
        else                      state_d = ST_SHIFT;
      end
      ST_GAP: begin
        if (gap_end_s) state_d = ST_SHIFT;
        else           state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath control: next line bit, flags, counters, shifter commands.
  always_comb begin
    pat_d      = pat_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    o_d        = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_din_s   = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d = new_pat_s;
          rep_d = reps_in;
          gap_d = gap_in;
          if (reps_in == '0) begin
            done_d = 1'b1;
          end else begin
            sh_load_s = 1'b1;
            sh_din_s  = new_pat_s;
            o_d       = sh_head_s;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (!sh_last_s) begin
          sh_shift_s = 1'b1;
          o_d        = sh_head_s;
          valid_d    = 1'b1;
        end else if (last_rep_s) begin
          rep_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          rep_d = rep_q - REPW'(1'b1);
          if (gap_q != '0) begin
            gcnt_d = gap_q;
          end else begin
            sh_load_s = 1'b1;
            o_d       = sh_head_s;
            valid_d   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_end_s) begin
          gcnt_d    = '0;
          sh_load_s = 1'b1;
          o_d       = sh_head_s;
          valid_d   = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAPW'(1'b1);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Latched request, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a per-cycle vector table plus
// hand-written sequences for back-to-back, held start and mid-frame reset.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst, start, use_def;
  logic [3:0] pattern_in, reps_in, gap_in;
  logic       o, o_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  seq_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .use_def    (use_def),
    .pattern_in (pattern_in),
    .reps_in    (reps_in),
    .gap_in     (gap_in),
    .o          (o),
    .o_valid    (o_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, u;
    logic [3:0] pat, reps, gap;
    logic [3:0] exp;   // {o, o_valid, busy, done} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, u, input logic [3:0] pat, reps, gap, input logic [3:0] exp);
    vec_t v;
    v.r = r; v.s = s; v.u = u; v.pat = pat; v.reps = reps; v.gap = gap; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, exp);
  endtask

  // Rows for the bits of one repetition, after the first bit was already produced.
  task automatic tail_bits(input logic [3:0] pat);
    for (int i = 2; i >= 0; i--) add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, {pat[i], 3'b110});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {o,valid,busy,done}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic [11:0] bits;
  logic [3:0]  det, b4;
  int          nvalid, hits;

  initial begin
    rst = 1'b1; start = 1'b0; use_def = 1'b0;
    pattern_in = 4'd0; reps_in = 4'd0; gap_in = 4'd0;

    // reset 3 cycles, idle 5
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000);
    idle(5, 4'b0000);
    // single frame, default pattern 1101 (pattern_in deliberately different)
    add(1'b0, 1'b1, 1'b1, 4'b0010, 4'd1, 4'd0, 4'b1110);
    tail_bits(4'b1101);
    idle(1, 4'b0001);
    idle(1, 4'b0000);
    // 1010, reps=2, gap=3
    add(1'b0, 1'b1, 1'b0, 4'b1010, 4'd2, 4'd3, 4'b1110);
    tail_bits(4'b1010);
    idle(3, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110);
    tail_bits(4'b1010);
    idle(1, 4'b0001);
    idle(1, 4'b0000);
    // reps=0: done only
    add(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 4'b0001);
    idle(2, 4'b0000);
    // explicit pattern 0110, single rep: first bit is 0 but valid
    add(1'b0, 1'b1, 1'b0, 4'b0110, 4'd1, 4'd0, 4'b0110);
    tail_bits(4'b0110);
    idle(1, 4'b0001);
    idle(1, 4'b0000);
    // maximum gap of 15 between two reps of 1001
    add(1'b0, 1'b1, 1'b0, 4'b1001, 4'd2, 4'd15, 4'b1110);
    tail_bits(4'b1001);
    idle(15, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110);
    tail_bits(4'b1001);
    idle(1, 4'b0001);
    idle(1, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; start = vecs[i].s; use_def = vecs[i].u;
      pattern_in = vecs[i].pat; reps_in = vecs[i].reps; gap_in = vecs[i].gap;
      step();
      chk($sformatf("vec%0d", i), {o, o_valid, busy, done}, vecs[i].exp);
    end

    // back-to-back: default pattern, reps=3, gap=0, start pulses while busy
    start = 1'b1; use_def = 1'b1; pattern_in = 4'd0; reps_in = 4'd3; gap_in = 4'd0;
    step();
    bits = '0; det = '0; nvalid = 0; hits = 0;
    for (int c = 0; c < 12; c++) begin
      start = c[0]; use_def = 1'b0; pattern_in = 4'b0000; reps_in = 4'd1;
      if (o_valid === 1'b1) begin
        bits = {bits[10:0], o};
        det  = {det[2:0], o};
        nvalid++;
        if (det == 4'b1101) hits++;
      end
      step();
    end
    start = 1'b0;
    chk_val("b2b_bits", int'(bits), int'(12'b110111011101));
    chk_val("b2b_valid_cycles", nvalid, 12);
    chk_val("b2b_detector_hits", hits, 3);
    chk("b2b_done", {o, o_valid, busy, done}, 4'b0001);
    step();
    chk("b2b_after", {o, o_valid, busy, done}, 4'b0000);

    // start held high across the done cycle, busy-time inputs ignored
    start = 1'b1; use_def = 1'b1; pattern_in = 4'd0; reps_in = 4'd1; gap_in = 4'd0;
    step();
    b4 = '0;
    for (int c = 0; c < 4; c++) begin
      b4 = {b4[2:0], o};
      if (c == 0) begin use_def = 1'b0; pattern_in = 4'b0000; reps_in = 4'd5; end
      if (c == 2) begin pattern_in = 4'b0110; reps_in = 4'd1; end
      step();
    end
    chk_val("held_first_bits", int'(b4), int'(4'b1101));
    chk("held_done", {o, o_valid, busy, done}, 4'b0001);
    step();
    chk("held_restart", {o, o_valid, busy, done}, 4'b0110);
    start = 1'b0;
    b4 = {3'b000, o};
    for (int c = 0; c < 3; c++) begin
      step();
      b4 = {b4[2:0], o};
    end
    chk_val("held_second_bits", int'(b4), int'(4'b0110));
    step();
    chk("held_second_done", {o, o_valid, busy, done}, 4'b0001);
    step();

    // reset during the second bit of a reps=2 frame
    start = 1'b1; use_def = 1'b1; reps_in = 4'd2; gap_in = 4'd0;
    step();
    start = 1'b0;
    step();
    chk("rst_bit2", {o, o_valid, busy, done}, 4'b1110);
    rst = 1'b1;
    step();
    chk("rst_clear", {o, o_valid, busy, done}, 4'b0000);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst_quiet%0d", c), {o, o_valid, busy, done}, 4'b0000);
    end
    start = 1'b1; use_def = 1'b0; pattern_in = 4'b1010; reps_in = 4'd1;
    step();
    start = 1'b0;
    chk("rst_new_b0", {o, o_valid, busy, done}, 4'b1110);
    step();
    chk("rst_new_b1", {o, o_valid, busy, done}, 4'b0110);
    step();
    chk("rst_new_b2", {o, o_valid, busy, done}, 4'b1110);
    step();
    chk("rst_new_b3", {o, o_valid, busy, done}, 4'b0110);
    step();
    chk("rst_new_done", {o, o_valid, busy, done}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
